// File: rtl/seq_scan_ctrl_pkg.sv
// Shared types and reset-time configuration for the serial scan controller.
package seq_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int          LEN_W       = 4;
    localparam logic [3:0]  DEF_PAT     = 4'b0110;
    localparam logic [3:0]  DEF_LEN     = 4'd4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Lengths beyond the detector window are treated as the full window.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int pat_max);
        if (int'(len) > pat_max)
            return LEN_W'(pat_max);
        return len;
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word-input valid/ready handshake between the producer and the scan controller.
interface seq_scan_ctrl_if #(
    parameter int WORD_W = 16
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_match_core.sv
// Serial pattern detector: history shift register, fill counter and
// length-masked compare with optional non-overlapping restart.
module seq_match_core
    import seq_scan_ctrl_pkg::*;
#(
    parameter int PAT_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               shift_en,
    input  logic               clear,
    input  logic [PAT_MAX-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               match
);
    localparam int FILL_W = $clog2(PAT_MAX + 1);

    // Only PAT_MAX-1 bits are stored; the incoming bit completes the window.
    logic [PAT_MAX-2:0] hist_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] len_mask;
    logic [FILL_W-1:0]  fill_next;

    assign window    = {hist_reg, bit_in};
    assign fill_next = (int'(fill_reg) == PAT_MAX) ? fill_reg : fill_reg + 1'b1;

    for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
        assign len_mask[gi] = (len > LEN_W'(gi));
    end

    assign match = shift_en && (len != '0) && (int'(fill_next) >= int'(len))
                   && (((window ^ pat) & len_mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (clear) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (shift_en) begin
            hist_reg <= window[PAT_MAX-2:0];
            fill_reg <= (match && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts words over valid/ready, feeds them MSB-first into the serial
// detector, and reports per-bit hits and a saturating per-word match count.
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [PAT_MAX-1:0]        cfg_pat,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      flush,
    seq_scan_ctrl_if.slave            in_bus,
    output logic                      busy,
    output logic                      hit,
    output logic [$clog2(WORD_W)-1:0] hit_pos,
    output logic                      done,
    output logic [CNT_W-1:0]          match_count
);
    localparam int IDX_W = $clog2(WORD_W);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [WORD_W-1:0]  data_reg;
    logic [PAT_MAX-1:0] pat_reg;
    logic [LEN_W-1:0]   len_reg;
    logic               overlap_reg;
    logic               hit_reg;
    logic [IDX_W-1:0]   hit_pos_reg;
    logic [CNT_W-1:0]   count_reg;

    logic idle, accept, cfg_wr, core_clear, shift_en, match;

    assign idle       = (state_reg == ST_IDLE);
    assign accept     = idle && in_bus.in_valid;
    assign cfg_wr     = idle && cfg_we;
    assign core_clear = cfg_wr || (idle && flush);
    assign shift_en   = (state_reg == ST_SHIFT);

    assign in_bus.in_ready = idle;
    assign busy            = (state_reg == ST_SHIFT) || (state_reg == ST_REPORT);
    assign done            = (state_reg == ST_REPORT);
    assign hit             = hit_reg;
    assign hit_pos         = hit_pos_reg;
    assign match_count     = count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (in_bus.in_valid) state_next = ST_SHIFT;
            ST_SHIFT:  if (idx_reg == IDX_W'(WORD_W - 1)) state_next = ST_REPORT;
            ST_REPORT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg     <= PAT_MAX'(DEF_PAT);
            len_reg     <= DEF_LEN;
            overlap_reg <= DEF_OVERLAP;
        end else if (cfg_wr) begin
            pat_reg     <= cfg_pat;
            len_reg     <= clamp_len(cfg_len, PAT_MAX);
            overlap_reg <= cfg_overlap;
        end
    end

    // The word is shifted left so the next serial bit is always the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_reg    <= '0;
            idx_reg     <= '0;
            hit_reg     <= 1'b0;
            hit_pos_reg <= '0;
            count_reg   <= '0;
        end else begin
            hit_reg <= match;
            if (match)
                hit_pos_reg <= idx_reg;
            if (accept) begin
                data_reg  <= in_bus.in_data;
                idx_reg   <= '0;
                count_reg <= '0;
            end else if (shift_en) begin
                data_reg <= {data_reg[WORD_W-2:0], 1'b0};
                idx_reg  <= idx_reg + 1'b1;
                if (match && (count_reg != {CNT_W{1'b1}}))
                    count_reg <= count_reg + 1'b1;
            end
        end
    end

    seq_match_core #(
        .PAT_MAX (PAT_MAX)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (data_reg[WORD_W-1]),
        .shift_en (shift_en),
        .clear    (core_clear),
        .pat      (pat_reg),
        .len      (len_reg),
        .overlap  (overlap_reg),
        .match    (match)
    );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: a CNT_W=5 instance plus a CNT_W=2 twin
// driven identically to observe count saturation.
module tb_seq_scan_ctrl;
    localparam int WORD_W  = 16;
    localparam int PAT_MAX = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_we = 1'b0;
    logic [PAT_MAX-1:0] cfg_pat = '0;
    logic [3:0]         cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               flush = 1'b0;

    logic       busy, hit, done;
    logic [3:0] hit_pos;
    logic [4:0] match_count;
    logic       busy2, hit2, done2;
    logic [3:0] hit_pos2;
    logic [1:0] match_count2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hit_cnt = 0;
    int done_cnt = 0;
    int done_before = 0;
    logic [15:0] hit_mask = '0;

    seq_scan_ctrl_if #(.WORD_W(WORD_W)) bus1 ();
    seq_scan_ctrl_if #(.WORD_W(WORD_W)) bus2 ();

    assign bus2.in_valid = bus1.in_valid;
    assign bus2.in_data  = bus1.in_data;

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .flush(flush), .in_bus(bus1), .busy(busy),
        .hit(hit), .hit_pos(hit_pos), .done(done), .match_count(match_count)
    );

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .flush(flush), .in_bus(bus2), .busy(busy2),
        .hit(hit2), .hit_pos(hit_pos2), .done(done2), .match_count(match_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (hit === 1'b1) begin
            hit_mask = hit_mask | (16'(1) << hit_pos);
            hit_cnt  = hit_cnt + 1;
        end
        if (done === 1'b1)
            done_cnt = done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
        cfg_we      = 1'b1;
        cfg_pat     = p;
        cfg_len     = l;
        cfg_overlap = ov;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_word(input logic [15:0] d);
        int n;
        n = 0;
        while (bus1.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus1.in_ready !== 1'b1)
            chk("ready_wait", {31'd0, bus1.in_ready}, 32'd1);
        hit_mask = '0;
        hit_cnt  = 0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = d;
        @(negedge clk);
        acc_cyc = cyc;
        bus1.in_valid = 1'b0;
        bus1.in_data  = 16'($urandom);
    endtask

    task automatic finish_word(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'd17);
        @(negedge clk);
    endtask

    initial begin
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus1.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", 32'(match_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: defaults on 6666
        start_word(16'h6666);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_in_ready", {31'd0, bus1.in_ready}, 32'd0);
        finish_word("t1");
        chk("t1_count", 32'(match_count), 32'd4);
        chk("t1_hit_mask", 32'(hit_mask), 32'h8888);
        chk("t1_hit_cnt", 32'(hit_cnt), 32'd4);

        // 2: 101 overlapping, then non-overlapping; twin saturates at 3
        do_cfg(8'b101, 4'd3, 1'b1);
        start_word(16'hAAAA);
        finish_word("t2a");
        chk("t2a_count", 32'(match_count), 32'd7);
        chk("t2a_hit_mask", 32'(hit_mask), 32'h5554);
        chk("t5_sat_count", 32'(match_count2), 32'd3);
        do_cfg(8'b101, 4'd3, 1'b0);
        start_word(16'hAAAA);
        finish_word("t2b");
        chk("t2b_count", 32'(match_count), 32'd4);
        chk("t2b_hit_mask", 32'(hit_mask), 32'h4444);

        // 3: boundary-spanning match, then the same with a flush in between
        do_cfg(8'b0110, 4'd4, 1'b1);
        start_word(16'h0003);
        finish_word("t3a");
        chk("t3a_count", 32'(match_count), 32'd0);
        start_word(16'h0000);
        finish_word("t3b");
        chk("t3b_count", 32'(match_count), 32'd1);
        chk("t3b_hit_mask", 32'(hit_mask), 32'h0001);
        start_word(16'h0003);
        finish_word("t3c");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start_word(16'h0000);
        finish_word("t3d");
        chk("t3d_count", 32'(match_count), 32'd0);
        chk("t3d_hit_mask", 32'(hit_mask), 32'h0000);

        // length clamp: 15 acts as 8
        do_cfg(8'b0110_0110, 4'd15, 1'b1);
        start_word(16'h6666);
        finish_word("clamp");
        chk("clamp_count", 32'(match_count), 32'd3);
        chk("clamp_hit_mask", 32'(hit_mask), 32'h8880);

        // 4: len=0 while busy is ignored; in IDLE it disables detection
        do_cfg(8'b0110, 4'd4, 1'b1);
        start_word(16'h6666);
        @(negedge clk);
        do_cfg(8'b0, 4'd0, 1'b1);
        finish_word("t4a");
        chk("t4a_count", 32'(match_count), 32'd4);
        chk("t4a_hit_mask", 32'(hit_mask), 32'h8888);
        do_cfg(8'b0110, 4'd0, 1'b1);
        start_word(16'h6666);
        finish_word("t4b");
        chk("t4b_count", 32'(match_count), 32'd0);
        chk("t4b_hit_cnt", 32'(hit_cnt), 32'd0);

        // 6: reset at k=5 aborts and restores default config
        do_cfg(8'b101, 4'd3, 1'b0);
        start_word(16'h6666);
        repeat (5) @(negedge clk);
        done_before = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("t6_in_ready", {31'd0, bus1.in_ready}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_count", 32'(match_count), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt), 32'(done_before));
        start_word(16'h6666);
        finish_word("t6b");
        chk("t6b_count", 32'(match_count), 32'd4);
        chk("t6b_hit_mask", 32'(hit_mask), 32'h8888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
